// File: rtl/conv3x3_param_pkg.sv
// Shared definitions for the 3x3 convolution block.
// Holds the kernel select encoding, the Sobel coefficient tables and the
// accumulator width rule used by the MAC stage.
package conv3x3_param_pkg;

  // Kernel select encoding as presented on iMODE.
  typedef enum logic [1:0] {
    MODE_SOBEL_Y = 2'd0,
    MODE_SOBEL_X = 2'd1,
    MODE_IDENT   = 2'd2,
    MODE_GRAD    = 2'd3
  } mode_e;

  // Four guard bits cover the worst case |Gx|+|Gy| = 8 * max pixel plus sign.
  localparam int ACC_GUARD = 4;

  function automatic int acc_width(input int data_w);
    return data_w + ACC_GUARD;
  endfunction

  typedef logic signed [2:0] coef_t;
  // Indexed [row][col]; row 0 is the oldest line (y-2), col 0 is x-2.
  typedef coef_t kernel_t [3][3];

  localparam kernel_t SOBEL_Y = '{
    '{-3'sd1, -3'sd2, -3'sd1},
    '{ 3'sd0,  3'sd0,  3'sd0},
    '{ 3'sd1,  3'sd2,  3'sd1}
  };

  localparam kernel_t SOBEL_X = '{
    '{-3'sd1,  3'sd0,  3'sd1},
    '{-3'sd2,  3'sd0,  3'sd2},
    '{-3'sd1,  3'sd0,  3'sd1}
  };

endpackage

// File: rtl/conv3x3_param_if.sv
// Pixel stream bundle for conv3x3_param.
// Signals:
//   iDATA  pixel in (raster order)      iDVAL  pixel valid
//   iSOF   start of frame qualifier     iMODE  kernel select
//   iABS   magnitude/clamp select       oDATA  filtered pixel
//   oDVAL  filtered pixel valid
// master: pixel source side; slave: the filter.
interface conv3x3_param_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic              iSOF;
  logic [1:0]        iMODE;
  logic              iABS;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;

  modport master (
    output iDATA, iDVAL, iSOF, iMODE, iABS,
    input  oDATA, oDVAL
  );

  modport slave (
    input  iDATA, iDVAL, iSOF, iMODE, iABS,
    output oDATA, oDVAL
  );
endinterface

// File: rtl/conv3x3_param_line_buf.sv
// conv_line_buf: two chained IMG_W-deep shift registers of DATA_W pixels.
// Ports:
//   i_clk    clock
//   i_en     shift enable (one accepted pixel)
//   i_data   incoming pixel
//   o_tap1   pixel one line back (same column, previous row)
//   o_tap2   pixel two lines back
// Storage is intentionally not reset; downstream border masking hides it.
module conv_line_buf #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_tap1,
  output logic [DATA_W-1:0] o_tap2
);
  logic [DATA_W-1:0] r_line1 [IMG_W];
  logic [DATA_W-1:0] r_line2 [IMG_W];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_line1[0] <= i_data;
      r_line2[0] <= r_line1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        r_line1[i] <= r_line1[i-1];
        r_line2[i] <= r_line2[i-1];
      end
    end
  end

  // The last element is read before the shift, so it is exactly IMG_W
  // accepted pixels old when the new pixel arrives.
  assign o_tap1 = r_line1[IMG_W-1];
  assign o_tap2 = r_line2[IMG_W-1];
endmodule

// File: rtl/conv3x3_param.sv
// conv3x3_param: streaming 3x3 filter (Sobel-Y, Sobel-X, identity, |Gx|+|Gy|).
// Ports:
//   iCLK   clock, all state on rising edge
//   iRST   asynchronous active-low reset
//   bus    conv3x3_param_if.slave pixel stream (iDATA/iDVAL/iSOF/iMODE/iABS
//          in, oDATA/oDVAL out)
// Output is the window centred on (x-1,y-1) of the pixel accepted two cycles
// earlier; positions with x<2 or y<2 emit 0.
module conv3x3_param
  import conv3x3_param_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic            iCLK,
  input logic            iRST,
  conv3x3_param_if.slave bus
);
  localparam int ACC_W = acc_width(DATA_W);
  localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t abs_acc(input acc_t v);
    return (v < 0) ? -v : v;
  endfunction

  // Negative results fold to magnitude or clamp to zero, then saturate.
  function automatic logic [DATA_W-1:0] sat_clamp(input acc_t v, input logic abs_en);
    acc_t mag;
    mag = v;
    if (v < 0) mag = abs_en ? -v : '0;
    if (mag > acc_t'(PIX_MAX)) return PIX_MAX;
    return mag[DATA_W-1:0];
  endfunction

  logic [X_W-1:0]    r_x, w_x_eff;
  logic [Y_W-1:0]    r_y, w_y_eff;
  logic              w_at_origin, w_last_col, w_last_row, w_border;
  mode_e             r_mode;
  logic              r_abs;
  logic [DATA_W-1:0] w_tap1, w_tap2;
  logic [DATA_W-1:0] r_top_d1, r_top_d2, r_mid_d1, r_mid_d2, r_bot_d1, r_bot_d2;
  logic [DATA_W-1:0] w_win [3][3];
  acc_t              w_gx, w_gy, w_res;

  acc_t              r_res_p1;
  logic              r_border_p1, r_abs_p1, r_vld_p1;
  logic [DATA_W-1:0] r_data_p2;
  logic              r_vld_p2;

  // ---- stage 0: position tracking, window assembly, MAC ----
  // iSOF overrides the counters for the pixel it qualifies.
  assign w_x_eff     = bus.iSOF ? '0 : r_x;
  assign w_y_eff     = bus.iSOF ? '0 : r_y;
  assign w_at_origin = (w_x_eff == '0) && (w_y_eff == '0);
  assign w_last_col  = (w_x_eff == X_W'(IMG_W - 1));
  assign w_last_row  = (w_y_eff == Y_W'(IMG_H - 1));
  assign w_border    = (w_x_eff < X_W'(2)) || (w_y_eff < Y_W'(2));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x    <= '0;
      r_y    <= '0;
      r_mode <= MODE_SOBEL_Y;
      r_abs  <= 1'b0;
    end else if (bus.iDVAL) begin
      if (w_last_col) begin
        r_x <= '0;
        r_y <= w_last_row ? '0 : w_y_eff + Y_W'(1);
      end else begin
        r_x <= w_x_eff + X_W'(1);
        r_y <= w_y_eff;
      end
      // The origin pixel itself is always border-masked, so it does not
      // matter that it is still filtered with the previous frame's mode.
      if (w_at_origin) begin
        r_mode <= mode_e'(bus.iMODE);
        r_abs  <= bus.iABS;
      end
    end
  end

  conv_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_line_buf (
    .i_clk  (iCLK),
    .i_en   (bus.iDVAL),
    .i_data (bus.iDATA),
    .o_tap1 (w_tap1),
    .o_tap2 (w_tap2)
  );

  always_ff @(posedge iCLK) begin
    if (bus.iDVAL) begin
      r_top_d1 <= w_tap2;
      r_top_d2 <= r_top_d1;
      r_mid_d1 <= w_tap1;
      r_mid_d2 <= r_mid_d1;
      r_bot_d1 <= bus.iDATA;
      r_bot_d2 <= r_bot_d1;
    end
  end

  assign w_win[0][0] = r_top_d2;
  assign w_win[0][1] = r_top_d1;
  assign w_win[0][2] = w_tap2;
  assign w_win[1][0] = r_mid_d2;
  assign w_win[1][1] = r_mid_d1;
  assign w_win[1][2] = w_tap1;
  assign w_win[2][0] = r_bot_d2;
  assign w_win[2][1] = r_bot_d1;
  assign w_win[2][2] = bus.iDATA;

  always_comb begin
    w_gx  = '0;
    w_gy  = '0;
    w_res = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_gy = w_gy + acc_t'(SOBEL_Y[r][c]) * acc_t'(w_win[r][c]);
        w_gx = w_gx + acc_t'(SOBEL_X[r][c]) * acc_t'(w_win[r][c]);
      end
    end
    case (r_mode)
      MODE_SOBEL_Y: w_res = w_gy;
      MODE_SOBEL_X: w_res = w_gx;
      MODE_IDENT:   w_res = acc_t'(w_win[1][1]);
      MODE_GRAD:    w_res = abs_acc(w_gx) + abs_acc(w_gy);
      default:      w_res = '0;
    endcase
  end

  // ---- stage 1: registered filter result ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_vld_p1    <= 1'b0;
      r_res_p1    <= '0;
      r_border_p1 <= 1'b1;
      r_abs_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= bus.iDVAL;
      if (bus.iDVAL) begin
        r_res_p1    <= w_res;
        r_border_p1 <= w_border;
        // Gradient magnitude is already non-negative; iABS is irrelevant.
        r_abs_p1    <= r_abs && (r_mode != MODE_GRAD);
      end
    end
  end

  // ---- stage 2: abs/clamp, saturation, border mask ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= r_border_p1 ? '0 : sat_clamp(r_res_p1, r_abs_p1);
      end
    end
  end

  assign bus.oDATA = r_data_p2;
  assign bus.oDVAL = r_vld_p2;
endmodule

// File: doc/conv3x3_param.md
CONV3X3_PARAM -- requirements
Module: conv3x3_param

Interface
REQ-001 Parameter DATA_W, default 12: pixel width in and out.
REQ-002 Parameter IMG_W, default 640: pixels per line; line buffer depth.
REQ-003 Parameter IMG_H, default 480: lines per frame.
REQ-004 iCLK  input  1  sole clock; all state on rising edge.
REQ-005 iRST  input  1  reset, asynchronous, active-low.
REQ-006 iDATA  input  DATA_W  unsigned pixel, raster order.
REQ-007 iDVAL  input  1  iDATA valid this cycle.
REQ-008 iSOF  input  1  start of frame; qualifies the pixel with iDVAL=1 as (0,0).
REQ-009 iMODE  input  2  kernel select: 0 Sobel-Y, 1 Sobel-X, 2 identity, 3 |Gx|+|Gy|.
REQ-010 iABS  input  1  1: negative result becomes its magnitude; 0: negative clamps to 0.
REQ-011 oDATA  output  DATA_W  filtered pixel.
REQ-012 oDVAL  output  1  oDATA valid.

Function
REQ-013 Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) SHALL advance only on iDVAL=1; x wraps to 0 and increments y; y wraps to 0 after IMG_H-1.
REQ-014 A pixel with iDVAL=1 and iSOF=1 SHALL be taken as x=0, y=0; counters continue from there.
REQ-015 iMODE and iABS SHALL be latched only on an accepted pixel at x=0,y=0 (either by iSOF or by wrap); mid-frame changes are ignored until the next frame.
REQ-016 Line buffer and horizontal delay registers SHALL shift only on iDVAL=1; gaps in iDVAL do not disturb the window.
REQ-017 Window on an accepted pixel at (x,y): rows y-2,y-1,y; columns x-2,x-1,x; the output pixel belongs to centre (x-1,y-1).
REQ-018 Sobel-Y: top row -1,-2,-1; middle 0; bottom +1,+2,+1. Sobel-X: left column -1,-2,-1; right column +1,+2,+1. Identity: centre pixel only.
REQ-019 Products and sums SHALL be signed with width DATA_W+4; no intermediate overflow.
REQ-020 Mode 3 SHALL sum the absolute values of Gx and Gy; iABS has no effect.
REQ-021 Final result SHALL saturate to 2^DATA_W-1; after iABS handling it is never negative.
REQ-022 Border: when x<2 or y<2, oDATA SHALL be 0 with oDVAL=1, so stale line-buffer data never reaches the output.
REQ-023 Latency: oDVAL SHALL equal iDVAL delayed exactly 2 cycles; oDATA corresponds to the pixel accepted 2 cycles earlier.
REQ-024 The pipeline SHALL be free-running; oDVAL=0 cycles carry don't-care oDATA, held at its previous value.

Reset
REQ-025 While iRST=0: oDATA=0, oDVAL=0, x=0, y=0, pipeline cleared, latched mode=0, latched abs=0.
REQ-026 Line buffer storage SHALL need no reset; REQ-022 masks its contents.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first accepted pixel after release is (0,0).

Structure
REQ-028 A shared package SHALL hold the mode encodings, the Sobel coefficient tables and the derived accumulator width.
REQ-029 The line buffer SHALL be one sub-module, conv_line_buf: parametric DATA_W x IMG_W shift register with clock enable and two taps (1 and 2 lines back).
REQ-030 The MAC, abs/clamp and border mask SHALL occupy the two output pipeline stages.

Verification
REQ-031 IMG_W=8, IMG_H=6, constant 100, mode 0 -> border outputs 0, interior outputs 0, oDVAL 2 cycles after iDVAL.
REQ-032 Rows 0-2 = 0, rows 3+ = 1000, mode 0, iABS=0 -> 4000 at y=3 and y=4 interior, 0 elsewhere; flip rows with iABS=1 -> 4000; with iABS=0 -> 0.
REQ-033 Vertical edge (cols 0-3 = 0, cols 4+ = 4095), mode 3 -> 4095 (saturated) at x=4,5 interior, 0 elsewhere.
REQ-034 Mode 2, iDVAL toggled 1-0-1 randomly -> output equals centre pixel; gaps do not shift the window.
REQ-035 iMODE changed mid-frame from 2 to 0 -> identity output until next (0,0), then Sobel-Y.
REQ-036 iRST pulsed at x=5,y=3 -> oDVAL=0 and oDATA=0 at once; after release, next frame starts at (0,0) with border outputs 0.
